// File: rtl/mem_stall_ctrl.sv
// MEM-stage sequencer for a variable-latency data memory: issues one req/ack
// transaction per load/store, stalls the pipeline until it completes or times out.
module mem_stall_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o,
    output logic [31:0]       stall_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       access;

    assign access  = MemRead_i | MemWrite_i;
    assign stall_o = ((state == IDLE) && access) || (state == WAIT);

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            rdata_o     <= '0;
            err_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        mem_addr_o  <= addr_i;
                        mem_wdata_o <= wdata_i;
                        mem_we_o    <= MemWrite_i;
                        mem_req_o   <= 1'b1;
                        wait_cnt    <= '0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    // Ack wins over a timeout landing in the same cycle.
                    if (mem_ack_i) begin
                        if (!mem_we_o) begin
                            rdata_o <= mem_rdata_i;
                        end
                        mem_req_o <= 1'b0;
                        state     <= DONE;
                    end else if (wait_cnt == LAST_WAIT) begin
                        rdata_o   <= '0;
                        err_o     <= 1'b1;
                        mem_req_o <= 1'b0;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    // The access still visible here is the one just retired.
                    err_o <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    mem_req_o <= 1'b0;
                    err_o     <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if (stall_o && (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Directed bench for mem_stall_ctrl with TIMEOUT = 4: loads, stores, write
// priority, timeout, reset mid-transaction, back-to-back and counter saturation.
module tb_mem_stall_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRead_i, MemWrite_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o, mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i, rdata_o;
    logic        err_o;
    logic [31:0] stall_cnt_o;

    int tests  = 0;
    int failed = 0;
    logic [31:0] exp_cnt;

    mem_stall_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs for a cycle are applied 2 units after its rising edge; checks follow 1 unit later.
    task automatic cyc();
        @(posedge clk_i);
        #2;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; MemRead_i = 1'b0; MemWrite_i = 1'b0; addr_i = '0; wdata_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        repeat (2) cyc();
        rst_i = 1'b0;
        #1;
        tests++; if (stall_o !== 1'b0)     begin failed++; $display("FAIL reset_stall got %h want 0", stall_o); end
        tests++; if (mem_req_o !== 1'b0)   begin failed++; $display("FAIL reset_req got %h want 0", mem_req_o); end
        tests++; if (mem_we_o !== 1'b0)    begin failed++; $display("FAIL reset_we got %h want 0", mem_we_o); end
        tests++; if (rdata_o !== 32'h0)    begin failed++; $display("FAIL reset_rdata got %h want 0", rdata_o); end
        tests++; if (err_o !== 1'b0)       begin failed++; $display("FAIL reset_err got %h want 0", err_o); end
        tests++; if (stall_cnt_o !== 32'h0) begin failed++; $display("FAIL reset_cnt got %h want 0", stall_cnt_o); end
        exp_cnt = 32'd0;
    endtask

    task automatic test_load();
        cyc(); MemRead_i = 1'b1; addr_i = 32'h100; #1;
        tests++; if (stall_o !== 1'b1)   begin failed++; $display("FAIL load_c0_stall got %h want 1", stall_o); end
        tests++; if (mem_req_o !== 1'b0) begin failed++; $display("FAIL load_c0_req got %h want 0", mem_req_o); end
        cyc(); #1;
        tests++; if (mem_req_o !== 1'b1)      begin failed++; $display("FAIL load_c1_req got %h want 1", mem_req_o); end
        tests++; if (mem_we_o !== 1'b0)       begin failed++; $display("FAIL load_c1_we got %h want 0", mem_we_o); end
        tests++; if (mem_addr_o !== 32'h100)  begin failed++; $display("FAIL load_c1_addr got %h want 100", mem_addr_o); end
        cyc(); #1;
        tests++; if (stall_o !== 1'b1) begin failed++; $display("FAIL load_c2_stall got %h want 1", stall_o); end
        cyc(); mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADBEEF; #1;
        tests++; if (stall_o !== 1'b1) begin failed++; $display("FAIL load_c3_stall got %h want 1", stall_o); end
        cyc(); mem_ack_i = 1'b0; mem_rdata_i = '0; #1;
        exp_cnt = exp_cnt + 32'd4;
        tests++; if (stall_o !== 1'b0)          begin failed++; $display("FAIL load_done_stall got %h want 0", stall_o); end
        tests++; if (mem_req_o !== 1'b0)        begin failed++; $display("FAIL load_done_req got %h want 0", mem_req_o); end
        tests++; if (rdata_o !== 32'hDEADBEEF)  begin failed++; $display("FAIL load_done_rdata got %h want deadbeef", rdata_o); end
        tests++; if (stall_cnt_o !== exp_cnt)   begin failed++; $display("FAIL load_cnt got %0d want %0d", stall_cnt_o, exp_cnt); end
        cyc(); MemRead_i = 1'b0; #1;
        tests++; if (stall_o !== 1'b0)        begin failed++; $display("FAIL load_after_stall got %h want 0", stall_o); end
        tests++; if (mem_req_o !== 1'b0)      begin failed++; $display("FAIL load_no_reissue got %h want 0", mem_req_o); end
        tests++; if (stall_cnt_o !== exp_cnt) begin failed++; $display("FAIL load_after_cnt got %0d want %0d", stall_cnt_o, exp_cnt); end
    endtask

    task automatic test_store();
        cyc(); MemWrite_i = 1'b1; addr_i = 32'h200; wdata_i = 32'h12345678; #1;
        tests++; if (stall_o !== 1'b1) begin failed++; $display("FAIL store_c0_stall got %h want 1", stall_o); end
        cyc(); mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFEF00D; #1;
        tests++; if (mem_req_o !== 1'b1)           begin failed++; $display("FAIL store_req got %h want 1", mem_req_o); end
        tests++; if (mem_we_o !== 1'b1)            begin failed++; $display("FAIL store_we got %h want 1", mem_we_o); end
        tests++; if (mem_addr_o !== 32'h200)       begin failed++; $display("FAIL store_addr got %h want 200", mem_addr_o); end
        tests++; if (mem_wdata_o !== 32'h12345678) begin failed++; $display("FAIL store_wdata got %h want 12345678", mem_wdata_o); end
        cyc(); mem_ack_i = 1'b0; mem_rdata_i = '0; #1;
        exp_cnt = exp_cnt + 32'd2;
        tests++; if (stall_o !== 1'b0)         begin failed++; $display("FAIL store_done_stall got %h want 0", stall_o); end
        tests++; if (rdata_o !== 32'hDEADBEEF) begin failed++; $display("FAIL store_rdata_kept got %h want deadbeef", rdata_o); end
        tests++; if (stall_cnt_o !== exp_cnt)  begin failed++; $display("FAIL store_cnt got %0d want %0d", stall_cnt_o, exp_cnt); end
        cyc(); MemWrite_i = 1'b0; #1;
    endtask

    task automatic test_write_priority();
        cyc(); mem_ack_i = 1'b1; mem_rdata_i = 32'h5A5A5A5A; #1;
        tests++; if (stall_o !== 1'b0) begin failed++; $display("FAIL stray_ack_stall got %h want 0", stall_o); end
        cyc(); mem_ack_i = 1'b0; MemRead_i = 1'b1; MemWrite_i = 1'b1; addr_i = 32'h300; wdata_i = 32'h55; #1;
        tests++; if (mem_req_o !== 1'b0) begin failed++; $display("FAIL stray_ack_req got %h want 0", mem_req_o); end
        tests++; if (stall_o !== 1'b1)   begin failed++; $display("FAIL both_c0_stall got %h want 1", stall_o); end
        cyc(); #1;
        tests++; if (mem_req_o !== 1'b1) begin failed++; $display("FAIL both_req got %h want 1", mem_req_o); end
        tests++; if (mem_we_o !== 1'b1)  begin failed++; $display("FAIL both_we got %h want 1", mem_we_o); end
        cyc(); mem_ack_i = 1'b1; mem_rdata_i = 32'hAAAAAAAA; #1;
        cyc(); mem_ack_i = 1'b0; #1;
        exp_cnt = exp_cnt + 32'd3;
        tests++; if (rdata_o !== 32'hDEADBEEF) begin failed++; $display("FAIL both_rdata_kept got %h want deadbeef", rdata_o); end
        tests++; if (stall_cnt_o !== exp_cnt)  begin failed++; $display("FAIL both_cnt got %0d want %0d", stall_cnt_o, exp_cnt); end
        cyc(); MemRead_i = 1'b0; MemWrite_i = 1'b0; #1;
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        cyc(); MemRead_i = 1'b1; addr_i = 32'h400; #1;
        for (int c = 1; c <= 4; c++) begin
            cyc();
            if (c == 2) addr_i = 32'hFFF;
            #1;
            if (mem_req_o === 1'b1) req_cycles++;
            tests++; if (stall_o !== 1'b1)       begin failed++; $display("FAIL to_wait%0d_stall got %h want 1", c, stall_o); end
            tests++; if (mem_addr_o !== 32'h400) begin failed++; $display("FAIL to_wait%0d_addr got %h want 400", c, mem_addr_o); end
        end
        cyc(); #1;
        if (mem_req_o === 1'b1) req_cycles++;
        exp_cnt = exp_cnt + 32'd5;
        tests++; if (req_cycles != 4)         begin failed++; $display("FAIL to_req_cycles got %0d want 4", req_cycles); end
        tests++; if (err_o !== 1'b1)          begin failed++; $display("FAIL to_err got %h want 1", err_o); end
        tests++; if (rdata_o !== 32'h0)       begin failed++; $display("FAIL to_rdata got %h want 0", rdata_o); end
        tests++; if (stall_o !== 1'b0)        begin failed++; $display("FAIL to_done_stall got %h want 0", stall_o); end
        tests++; if (stall_cnt_o !== exp_cnt) begin failed++; $display("FAIL to_cnt got %0d want %0d", stall_cnt_o, exp_cnt); end
        cyc(); MemRead_i = 1'b0; #1;
        tests++; if (err_o !== 1'b0)   begin failed++; $display("FAIL to_err_pulse got %h want 0", err_o); end
        tests++; if (stall_o !== 1'b0) begin failed++; $display("FAIL to_next_stall got %h want 0", stall_o); end
    endtask

    task automatic test_reset_mid();
        cyc(); MemWrite_i = 1'b1; addr_i = 32'h500; wdata_i = 32'h99; #1;
        cyc(); #1;
        tests++; if (mem_req_o !== 1'b1) begin failed++; $display("FAIL rst_pre_req got %h want 1", mem_req_o); end
        cyc(); rst_i = 1'b1; MemWrite_i = 1'b0; #1;
        tests++; if (mem_req_o !== 1'b0)      begin failed++; $display("FAIL rst_req got %h want 0", mem_req_o); end
        tests++; if (mem_we_o !== 1'b0)       begin failed++; $display("FAIL rst_we got %h want 0", mem_we_o); end
        tests++; if (mem_addr_o !== 32'h0)    begin failed++; $display("FAIL rst_addr got %h want 0", mem_addr_o); end
        tests++; if (mem_wdata_o !== 32'h0)   begin failed++; $display("FAIL rst_wdata got %h want 0", mem_wdata_o); end
        tests++; if (rdata_o !== 32'h0)       begin failed++; $display("FAIL rst_rdata got %h want 0", rdata_o); end
        tests++; if (stall_cnt_o !== 32'h0)   begin failed++; $display("FAIL rst_cnt got %h want 0", stall_cnt_o); end
        tests++; if (stall_o !== 1'b0)        begin failed++; $display("FAIL rst_stall got %h want 0", stall_o); end
        cyc(); rst_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h77; #1;
        tests++; if (stall_o !== 1'b0) begin failed++; $display("FAIL late_ack_stall got %h want 0", stall_o); end
        cyc(); mem_ack_i = 1'b0; #1;
        tests++; if (mem_req_o !== 1'b0)   begin failed++; $display("FAIL late_ack_req got %h want 0", mem_req_o); end
        tests++; if (rdata_o !== 32'h0)    begin failed++; $display("FAIL late_ack_rdata got %h want 0", rdata_o); end
        tests++; if (err_o !== 1'b0)       begin failed++; $display("FAIL late_ack_err got %h want 0", err_o); end
        exp_cnt = 32'd0;
    endtask

    task automatic test_back_to_back();
        cyc(); MemRead_i = 1'b1; addr_i = 32'h600; #1;
        cyc(); mem_ack_i = 1'b1; mem_rdata_i = 32'h11111111; #1;
        cyc(); mem_ack_i = 1'b0; #1;
        tests++; if (stall_o !== 1'b0)         begin failed++; $display("FAIL b2b_done1_stall got %h want 0", stall_o); end
        tests++; if (rdata_o !== 32'h11111111) begin failed++; $display("FAIL b2b_done1_rdata got %h want 11111111", rdata_o); end
        cyc(); addr_i = 32'h604; #1;
        tests++; if (stall_o !== 1'b1)   begin failed++; $display("FAIL b2b_idle_stall got %h want 1", stall_o); end
        tests++; if (mem_req_o !== 1'b0) begin failed++; $display("FAIL b2b_idle_req got %h want 0", mem_req_o); end
        cyc(); mem_ack_i = 1'b1; mem_rdata_i = 32'h22222222; #1;
        tests++; if (mem_addr_o !== 32'h604) begin failed++; $display("FAIL b2b_addr2 got %h want 604", mem_addr_o); end
        cyc(); mem_ack_i = 1'b0; #1;
        exp_cnt = exp_cnt + 32'd4;
        tests++; if (stall_o !== 1'b0)         begin failed++; $display("FAIL b2b_done2_stall got %h want 0", stall_o); end
        tests++; if (rdata_o !== 32'h22222222) begin failed++; $display("FAIL b2b_done2_rdata got %h want 22222222", rdata_o); end
        tests++; if (stall_cnt_o !== exp_cnt)  begin failed++; $display("FAIL b2b_cnt got %0d want %0d", stall_cnt_o, exp_cnt); end
        cyc(); MemRead_i = 1'b0; #1;
    endtask

    task automatic test_saturation();
        cyc();
        force dut.stall_cnt_o = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_o;
        cyc(); MemRead_i = 1'b1; addr_i = 32'h700; #1;
        cyc(); #1;
        cyc(); mem_ack_i = 1'b1; mem_rdata_i = 32'h33333333; #1;
        cyc(); mem_ack_i = 1'b0; #1;
        tests++; if (stall_cnt_o !== 32'hFFFF_FFFF) begin failed++; $display("FAIL sat_cnt got %h want ffffffff", stall_cnt_o); end
        cyc(); MemRead_i = 1'b1; addr_i = 32'h704; #1;
        cyc(); MemRead_i = 1'b0; #1;
        tests++; if (stall_cnt_o !== 32'hFFFF_FFFF) begin failed++; $display("FAIL sat_hold got %h want ffffffff", stall_cnt_o); end
        rst_i = 1'b1; #1; rst_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_write_priority();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mem_stall_ctrl.md
# mem_stall_ctrl

Sequencer for the MEM stage of the 5-stage RISC-V pipeline when data memory has variable latency. Takes the MemRead/MemWrite controls carried in EX/MEM, issues a request/acknowledge transaction to data memory, holds the whole pipeline with a stall signal until the access completes or times out, and returns the load data. It also keeps a saturating count of stall cycles for performance measurement.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, maximum WAIT cycles without ack before abort; legal range 1..255

- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- MemRead_i  in  1  EX/MEM load control
- MemWrite_i  in  1  EX/MEM store control
- addr_i  in  ADDR_W  ALU result from EX/MEM
- wdata_i  in  DATA_W  store data from EX/MEM
- stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM, MEM/WB (combinational)
- mem_req_o  out  1  memory request, registered
- mem_we_o  out  1  1 = write, registered
- mem_addr_o  out  ADDR_W  latched address
- mem_wdata_o  out  DATA_W  latched store data
- mem_ack_i  in  1  memory completion, one-cycle pulse
- mem_rdata_i  in  DATA_W  read data, valid with mem_ack_i
- rdata_o  out  DATA_W  load result toward MEM/WB
- err_o  out  1  one-cycle pulse on timeout abort
- stall_cnt_o  out  32  cycles with stall_o = 1, saturates at 0xFFFFFFFF

## Operation
- access = MemRead_i | MemWrite_i. If both are high, the access is a write; MemRead_i is ignored.
- States:
  - IDLE: if access, latch addr_i, wdata_i, and we = MemWrite_i. Set mem_req_o to 1 on the next edge, clear the timeout counter, and go to WAIT.
  - WAIT: mem_req_o = 1 and the counter increments each cycle.
    - If mem_ack_i = 1: capture mem_rdata_i into rdata_o (reads only; writes leave rdata_o unchanged), drop mem_req_o, go to DONE.
    - Else, if counter = TIMEOUT-1: drop mem_req_o, set rdata_o = 0, pulse err_o, go to DONE.
    - Ack takes priority over timeout in the same cycle.
  - DONE: stall_o = 0 and the pipeline advances one cycle, moving the completed instruction into WB with rdata_o. Go to IDLE unconditionally. An access visible in DONE is the instruction just completed and must not be reissued.
- stall_o = (state==IDLE & access) | (state==WAIT).
- mem_ack_i in IDLE or DONE is ignored. mem_addr_o, mem_wdata_o, and mem_we_o stay constant for the whole WAIT.
- stall_cnt_o increments on every edge where stall_o = 1, and holds at the saturation value.
- Reset, including mid-transaction:
  - state = IDLE; mem_req_o, mem_we_o, and err_o = 0.
  - mem_addr_o, mem_wdata_o, rdata_o, the timeout counter, and stall_cnt_o = 0.
  - The bus request drops asynchronously. A late ack after reset is ignored.

## Timing
- Cycle 0 (IDLE, access seen): stall_o = 1, mem_req_o = 0.
- Cycle 1: state WAIT, mem_req_o = 1.
- Ack in cycle k ≥ 1: cycle k+1 is DONE, with stall_o = 0, mem_req_o = 0, and rdata_o valid. Stall cycles = k+1.
- Timeout with no ack: WAIT lasts TIMEOUT cycles. err_o = 1 in the DONE cycle only. Stall cycles = TIMEOUT+1.
- Back-to-back memory instructions: the second enters MEM the cycle after DONE and starts a new IDLE→WAIT sequence. There is no overlap.
- A non-memory instruction in IDLE: stall_o = 0 and zero added latency.

## Test plan
- Load, 0x100, ack with rdata 0xDEADBEEF on cycle 3 → stall_o high cycles 0–3, mem_we_o = 0, rdata_o = 0xDEADBEEF and stall_o = 0 in cycle 4, stall_cnt_o = 4.
- Store, 0x200, wdata 0x12345678, ack on cycle 1 → mem_we_o = 1, mem_addr_o = 0x200, mem_wdata_o = 0x12345678 held through WAIT, rdata_o unchanged, stall_cnt_o = 2.
- MemRead_i and MemWrite_i both 1 → mem_we_o = 1. Stray mem_ack_i in IDLE → no state change.
- TIMEOUT = 4, no ack → mem_req_o high exactly 4 cycles, err_o pulses one cycle, rdata_o = 0, stall 5 cycles, next instruction proceeds.
- rst_i asserted in WAIT cycle 2 → mem_req_o = 0 immediately, all outputs zero. Ack one cycle later → ignored, state stays IDLE.
- Two consecutive loads, ack latency 1 each → two DONE cycles separated by one IDLE-stall cycle, stall_cnt_o = 4. Force stall_cnt_o to 0xFFFFFFFE and stall 3 cycles → stall_cnt_o = 0xFFFFFFFF.
